// File: rtl/motion_cntrl_pkg.sv
// motion_cntrl_pkg: state, channel, weight and saturation definitions for motion_cntrl.
// Optional integrator feature macro: MOTION_CNTRL_I_TERM_EN.
package motion_cntrl_pkg;

  localparam int ALU_W = 24;
  typedef logic signed [ALU_W-1:0] wide_t;

  typedef enum logic [3:0] {
    ST_IDLE, ST_SETTLE, ST_CONV_R, ST_WAIT_R, ST_ACC_R, ST_GAP, ST_CONV_L,
    ST_WAIT_L, ST_ACC_L, ST_INTG, ST_ITERM, ST_PTERM, ST_MRT_R, ST_MRT_L
  } state_e;

  typedef enum logic [1:0] {PAIR_IN = 2'd0, PAIR_MID = 2'd1, PAIR_OUT = 2'd2} pair_e;

  typedef enum logic [2:0] {ALU_PASS, ALU_MAC, ALU_MSC, ALU_MUL, ALU_ADD3, ALU_SUB3} alu_op_e;

  localparam logic [2:0] CH_IN_R  = 3'd1;
  localparam logic [2:0] CH_IN_L  = 3'd0;
  localparam logic [2:0] CH_MID_R = 3'd4;
  localparam logic [2:0] CH_MID_L = 3'd2;
  localparam logic [2:0] CH_OUT_R = 3'd3;
  localparam logic [2:0] CH_OUT_L = 3'd7;

  localparam logic [3:0] W_IN  = 4'd1;
  localparam logic [3:0] W_MID = 4'd2;
  localparam logic [3:0] W_OUT = 4'd4;

  localparam int SETTLE_CYCLES = 4096;
  localparam int GAP_CYCLES    = 32;

  localparam int SAT12_MIN = -2048;
  localparam int SAT12_MAX = 2047;
  localparam int SAT11_MIN = -1024;
  localparam int SAT11_MAX = 1023;

  function automatic logic signed [11:0] sat12(input wide_t v);
    if (v > wide_t'(SAT12_MAX))      sat12 = 12'(SAT12_MAX);
    else if (v < wide_t'(SAT12_MIN)) sat12 = 12'(SAT12_MIN);
    else                             sat12 = v[11:0];
  endfunction

  function automatic logic signed [10:0] sat11(input wide_t v);
    if (v > wide_t'(SAT11_MAX))      sat11 = 11'(SAT11_MAX);
    else if (v < wide_t'(SAT11_MIN)) sat11 = 11'(SAT11_MIN);
    else                             sat11 = v[10:0];
  endfunction

  function automatic logic [2:0] ch_right(input pair_e p);
    case (p)
      PAIR_IN:  ch_right = CH_IN_R;
      PAIR_MID: ch_right = CH_MID_R;
      default:  ch_right = CH_OUT_R;
    endcase
  endfunction

  function automatic logic [2:0] ch_left(input pair_e p);
    case (p)
      PAIR_IN:  ch_left = CH_IN_L;
      PAIR_MID: ch_left = CH_MID_L;
      default:  ch_left = CH_OUT_L;
    endcase
  endfunction

  function automatic logic [3:0] weight(input pair_e p);
    case (p)
      PAIR_IN:  weight = W_IN;
      PAIR_MID: weight = W_MID;
      default:  weight = W_OUT;
    endcase
  endfunction

endpackage

// File: rtl/motion_alu.sv
// motion_alu: shared add/subtract/multiply unit with 16-bit, sat12 and sat11 results.
module motion_alu
  import motion_cntrl_pkg::*;
(
  input  logic [2:0]              op,
  input  logic signed [ALU_W-1:0] a,
  input  logic signed [ALU_W-1:0] b,
  input  logic signed [ALU_W-1:0] c,
  input  logic [3:0]              k,
  output logic signed [15:0]      y16,
  output logic signed [11:0]      y_sat12,
  output logic signed [10:0]      y_sat11
);

  wide_t k_w;
  wide_t prod;
  wide_t y;

  // Operation select; k is an unsigned gain/weight applied to b.
  always_comb begin
    k_w  = {{(ALU_W-4){1'b0}}, k};
    prod = b * k_w;
    case (op)
      ALU_MAC:  y = a + prod;
      ALU_MSC:  y = a - prod;
      ALU_MUL:  y = prod;
      ALU_ADD3: y = a + b + c;
      ALU_SUB3: y = a - b - c;
      default:  y = a;
    endcase
    y16     = y[15:0];
    y_sat12 = sat12(y);
    y_sat11 = sat11(y);
  end

endmodule

// File: rtl/motion_cntrl.sv
// motion_cntrl: IR line-position sensing through the A2D plus PI steering control.
// Define MOTION_CNTRL_I_TERM_EN to enable the integrator; otherwise control is P-only.
module motion_cntrl
  import motion_cntrl_pkg::*;
#(
  parameter logic [3:0]  P_TERM   = 4'd2,
  parameter logic [3:0]  I_TERM   = 4'd1,
  parameter logic [10:0] FWD_STEP = 11'h010,
  parameter logic [10:0] FWD_MAX  = 11'h700
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        go,
  output logic        strt_cnv,
  output logic [2:0]  chnnl,
  input  logic        cnv_cmplt,
  input  logic [11:0] A2D_res,
  output logic        IR_in_en,
  output logic        IR_mid_en,
  output logic        IR_out_en,
  output logic [7:0]  LEDs,
  output logic [10:0] lft,
  output logic [10:0] rht
);

  localparam logic [11:0] SETTLE_LAST = 12'(SETTLE_CYCLES - 1);
  localparam logic [11:0] GAP_LAST    = 12'(GAP_CYCLES - 1);

  state_e             state_q, state_d;
  pair_e              pair_q, pair_d;
  logic [11:0]        cnt_q, cnt_d;
  logic [11:0]        res_q, res_d;
  logic signed [15:0] accum_q, accum_d;
  logic signed [11:0] error_q, error_d;
  logic signed [11:0] intgrl_q, intgrl_d;
  logic signed [15:0] icomp_q, icomp_d;
  logic signed [15:0] pcomp_q, pcomp_d;
  logic [10:0]        fwd_q, fwd_d;
  logic [1:0]         decim_q, decim_d;
  logic [10:0]        lft_q, lft_d;
  logic [10:0]        rht_q, rht_d;

  logic               settle_done, gap_done;
  logic [11:0]        fwd_sum;
  alu_op_e            alu_op;
  wide_t              alu_a, alu_b, alu_c;
  logic [3:0]         alu_k;
  logic signed [15:0] alu_y16;
  logic signed [11:0] alu_sat12;
  logic signed [10:0] alu_sat11;

  assign settle_done = (cnt_q == SETTLE_LAST);
  assign gap_done    = (cnt_q == GAP_LAST);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state: pair sequence, then post-processing; dropping go always returns to IDLE.
  always_comb begin
    // NOTE: default assignment first so no path leaves state_d unassigned (no latch).
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (go) state_d = ST_SETTLE;
      ST_SETTLE: if (settle_done) state_d = ST_CONV_R;
      ST_CONV_R: state_d = ST_WAIT_R;
      ST_WAIT_R: if (cnv_cmplt) state_d = ST_ACC_R;
      ST_ACC_R:  state_d = ST_GAP;
      ST_GAP:    if (gap_done) state_d = ST_CONV_L;
      ST_CONV_L: state_d = ST_WAIT_L;
      ST_WAIT_L: if (cnv_cmplt) state_d = ST_ACC_L;
      ST_ACC_L:  state_d = (pair_q == PAIR_OUT) ? ST_INTG : ST_SETTLE;
      ST_INTG:   state_d = ST_ITERM;
      ST_ITERM:  state_d = ST_PTERM;
      ST_PTERM:  state_d = ST_MRT_R;
      ST_MRT_R:  state_d = ST_MRT_L;
      ST_MRT_L:  state_d = ST_SETTLE;
      default:   state_d = ST_IDLE;
    endcase
    if (!go) state_d = ST_IDLE;
  end

  // Moore outputs: conversion request, channel select and the active pair's emitter.
  always_comb begin
    strt_cnv  = (state_q == ST_CONV_R) || (state_q == ST_CONV_L);
    chnnl     = 3'd0;
    IR_in_en  = 1'b0;
    IR_mid_en = 1'b0;
    IR_out_en = 1'b0;
    case (state_q)
      ST_CONV_R, ST_WAIT_R: chnnl = ch_right(pair_q);
      ST_CONV_L, ST_WAIT_L: chnnl = ch_left(pair_q);
      default: ;
    endcase
    if (state_q inside {ST_SETTLE, ST_CONV_R, ST_WAIT_R, ST_ACC_R, ST_GAP, ST_CONV_L, ST_WAIT_L}) begin
      IR_in_en  = (pair_q == PAIR_IN);
      IR_mid_en = (pair_q == PAIR_MID);
      IR_out_en = (pair_q == PAIR_OUT);
    end
  end

  // ALU operand steering: one operation per state.
  always_comb begin
    alu_op = ALU_PASS;
    alu_a  = '0;
    alu_b  = '0;
    alu_c  = '0;
    alu_k  = '0;
    case (state_q)
      ST_ACC_R: begin
        alu_op = ALU_MAC;
        alu_a  = wide_t'(accum_q);
        alu_b  = wide_t'(res_q);
        alu_k  = weight(pair_q);
      end
      ST_ACC_L: begin
        alu_op = ALU_MSC;
        alu_a  = wide_t'(accum_q);
        alu_b  = wide_t'(res_q);
        alu_k  = weight(pair_q);
      end
      ST_INTG:  alu_a = wide_t'(accum_q);
      ST_ITERM: begin
        alu_op = ALU_MUL;
        alu_b  = wide_t'(intgrl_q);
        alu_k  = I_TERM;
      end
      ST_PTERM: begin
        alu_op = ALU_MUL;
        alu_b  = wide_t'(error_q);
        alu_k  = P_TERM;
      end
      ST_MRT_R, ST_MRT_L: begin
        alu_op = (state_q == ST_MRT_R) ? ALU_SUB3 : ALU_ADD3;
        alu_a  = wide_t'(fwd_q);
        alu_b  = wide_t'(pcomp_q);
        alu_c  = wide_t'(icomp_q);
      end
      default: ;
    endcase
  end

  motion_alu u_alu (
    .op      (alu_op),
    .a       (alu_a),
    .b       (alu_b),
    .c       (alu_c),
    .k       (alu_k),
    .y16     (alu_y16),
    .y_sat12 (alu_sat12),
    .y_sat11 (alu_sat11)
  );

  // Datapath next values: what each state captures; dropping go clears the control state.
  always_comb begin
    pair_d   = pair_q;
    cnt_d    = '0;
    res_d    = res_q;
    accum_d  = accum_q;
    error_d  = error_q;
    intgrl_d = intgrl_q;
    icomp_d  = icomp_q;
    pcomp_d  = pcomp_q;
    fwd_d    = fwd_q;
    decim_d  = decim_q;
    lft_d    = lft_q;
    rht_d    = rht_q;
    fwd_sum  = {1'b0, fwd_q} + {1'b0, FWD_STEP};
    if (!go) begin
      fwd_d    = '0;
      intgrl_d = '0;
      decim_d  = '0;
      lft_d    = '0;
      rht_d    = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          pair_d  = PAIR_IN;
          accum_d = '0;
        end
        ST_SETTLE: if (!settle_done) cnt_d = cnt_q + 12'd1;
        ST_GAP:    if (!gap_done) cnt_d = cnt_q + 12'd1;
        ST_WAIT_R, ST_WAIT_L: if (cnv_cmplt) res_d = A2D_res;
        ST_ACC_R:  accum_d = alu_y16;
        ST_ACC_L: begin
          accum_d = alu_y16;
          if (pair_q == PAIR_IN)       pair_d = PAIR_MID;
          else if (pair_q == PAIR_MID) pair_d = PAIR_OUT;
        end
        ST_INTG: begin
          error_d = alu_sat12;
          fwd_d   = (fwd_sum > {1'b0, FWD_MAX}) ? FWD_MAX : fwd_sum[10:0];
          decim_d = decim_q + 2'd1;
`ifdef MOTION_CNTRL_I_TERM_EN
          if (decim_q == 2'd3)
            intgrl_d = sat12(wide_t'(intgrl_q) + wide_t'(alu_sat12 >>> 4));
`else
          intgrl_d = '0;
`endif
        end
        ST_ITERM: icomp_d = alu_y16;
        ST_PTERM: pcomp_d = alu_y16;
        ST_MRT_R: rht_d = alu_sat11;
        ST_MRT_L: begin
          lft_d   = alu_sat11;
          pair_d  = PAIR_IN;
          accum_d = '0;
        end
        default: ;
      endcase
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pair_q   <= PAIR_IN;
      cnt_q    <= '0;
      res_q    <= '0;
      accum_q  <= '0;
      error_q  <= '0;
      intgrl_q <= '0;
      icomp_q  <= '0;
      pcomp_q  <= '0;
      fwd_q    <= '0;
      decim_q  <= '0;
      lft_q    <= '0;
      rht_q    <= '0;
    end else begin
      pair_q   <= pair_d;
      cnt_q    <= cnt_d;
      res_q    <= res_d;
      accum_q  <= accum_d;
      error_q  <= error_d;
      intgrl_q <= intgrl_d;
      icomp_q  <= icomp_d;
      pcomp_q  <= pcomp_d;
      fwd_q    <= fwd_d;
      decim_q  <= decim_d;
      lft_q    <= lft_d;
      rht_q    <= rht_d;
    end
  end

  assign lft  = lft_q;
  assign rht  = rht_q;
  assign LEDs = error_q[11:4];

endmodule

// File: tb/tb_motion_cntrl.sv
// tb_motion_cntrl: directed bench for motion_cntrl with a bench-driven A2D responder.
// Expected values follow MOTION_CNTRL_I_TERM_EN the same way the design does.
module tb_motion_cntrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        go;
  logic        strt_cnv;
  logic [2:0]  chnnl;
  logic        cnv_cmplt;
  logic [11:0] A2D_res;
  logic        IR_in_en, IR_mid_en, IR_out_en;
  logic [7:0]  LEDs;
  logic [10:0] lft, rht;

  int n_pass  = 0;
  int n_total = 0;

  // Observations from the most recent sensing pass (6 conversions).
  int         waits [6];
  logic [2:0] chs   [6];
  logic [2:0] ens   [6];
  logic       sense_timeout;

  always #5 clk = ~clk;

  motion_cntrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .go        (go),
    .strt_cnv  (strt_cnv),
    .chnnl     (chnnl),
    .cnv_cmplt (cnv_cmplt),
    .A2D_res   (A2D_res),
    .IR_in_en  (IR_in_en),
    .IR_mid_en (IR_mid_en),
    .IR_out_en (IR_out_en),
    .LEDs      (LEDs),
    .lft       (lft),
    .rht       (rht)
  );

  // Wait (bounded) for strt_cnv, record channel and enables, answer 3 cycles later.
  task automatic serve_conv(input logic [11:0] res, input int budget, output int waited,
                            output logic [2:0] ch, output logic [2:0] en, output logic timed_out);
    waited    = 0;
    timed_out = 1'b1;
    ch        = 3'd0;
    en        = 3'd0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      waited++;
      if (strt_cnv === 1'b1) begin
        timed_out = 1'b0;
        break;
      end
    end
    if (!timed_out) begin
      ch = chnnl;
      en = {IR_out_en, IR_mid_en, IR_in_en};
      repeat (2) @(negedge clk);
      A2D_res   = res;
      cnv_cmplt = 1'b1;
      @(negedge clk);
      cnv_cmplt = 1'b0;
    end
  endtask

  // One full sensing pass: right result r and left result l for every pair.
  task automatic run_sense(input logic [11:0] r, input logic [11:0] l);
    int w; logic [2:0] c; logic [2:0] e; logic to;
    sense_timeout = 1'b0;
    for (int i = 0; i < 6; i++) begin
      serve_conv((i % 2 == 0) ? r : l, (i % 2 == 0) ? 5000 : 100, w, c, e, to);
      waits[i] = w;
      chs[i]   = c;
      ens[i]   = e;
      sense_timeout |= to;
    end
  endtask

  task automatic test_reset();
    logic seen;
    rst_n = 1'b0; go = 1'b0; cnv_cmplt = 1'b0; A2D_res = 12'h000;
    repeat (3) @(negedge clk);
    n_total++; if (strt_cnv !== 1'b0) $display("FAIL reset_strt_cnv: got %b want 0", strt_cnv); else n_pass++;
    n_total++; if (chnnl !== 3'd0) $display("FAIL reset_chnnl: got %0d want 0", chnnl); else n_pass++;
    n_total++; if ({IR_out_en, IR_mid_en, IR_in_en} !== 3'b000)
      $display("FAIL reset_enables: got %b want 000", {IR_out_en, IR_mid_en, IR_in_en}); else n_pass++;
    n_total++; if (LEDs !== 8'h00) $display("FAIL reset_leds: got %h want 00", LEDs); else n_pass++;
    n_total++; if (lft !== 11'h000) $display("FAIL reset_lft: got %h want 000", lft); else n_pass++;
    n_total++; if (rht !== 11'h000) $display("FAIL reset_rht: got %h want 000", rht); else n_pass++;
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (10000) begin
      @(negedge clk);
      if (strt_cnv !== 1'b0) seen = 1'b1;
    end
    n_total++; if (seen !== 1'b0) $display("FAIL idle_no_strt_cnv: got %b want 0", seen); else n_pass++;
  endtask

  // First control cycle: order of channels/enables, conversion spacing and PI result.
  task automatic test_first_cycle();
    logic [2:0] exp_ch [6] = '{3'd1, 3'd0, 3'd4, 3'd2, 3'd3, 3'd7};
    logic [2:0] exp_en [6] = '{3'b001, 3'b001, 3'b010, 3'b010, 3'b100, 3'b100};
    go = 1'b1;
    run_sense(12'h020, 12'h010);
    n_total++; if (sense_timeout !== 1'b0) $display("FAIL c1_strt_timeout: got %b want 0", sense_timeout); else n_pass++;
    n_total++; if (waits[0] !== 4097) $display("FAIL first_strt_delay: got %0d want 4097", waits[0]); else n_pass++;
    n_total++; if (waits[1] !== 33) $display("FAIL left_strt_delay: got %0d want 33", waits[1]); else n_pass++;
    for (int i = 0; i < 6; i++) begin
      n_total++; if (chs[i] !== exp_ch[i]) $display("FAIL chnnl_%0d: got %0d want %0d", i, chs[i], exp_ch[i]); else n_pass++;
      n_total++; if (ens[i] !== exp_en[i]) $display("FAIL enables_%0d: got %b want %b", i, ens[i], exp_en[i]); else n_pass++;
    end
    repeat (5) @(negedge clk);
    n_total++; if (rht !== 11'h730) $display("FAIL c1_rht: got %h want 730", rht); else n_pass++;
    n_total++; if (lft !== 11'h000) $display("FAIL c1_lft_early: got %h want 000", lft); else n_pass++;
    @(negedge clk);
    n_total++; if (lft !== 11'h0F0) $display("FAIL c1_lft: got %h want 0f0", lft); else n_pass++;
    n_total++; if (LEDs !== 8'h07) $display("FAIL c1_leds: got %h want 07", LEDs); else n_pass++;
  endtask

  // Control cycles 2..4 with the same stimulus: Fwd ramp and the decimated integrator.
`ifdef MOTION_CNTRL_I_TERM_EN
  localparam logic [10:0] C4_LFT = 11'h127;
  localparam logic [10:0] C4_RHT = 11'h759;
`else
  localparam logic [10:0] C4_LFT = 11'h120;
  localparam logic [10:0] C4_RHT = 11'h760;
`endif
  task automatic test_integrator();
    logic [10:0] exp_l [3] = '{11'h100, 11'h110, C4_LFT};
    logic [10:0] exp_r [3] = '{11'h740, 11'h750, C4_RHT};
    for (int c = 0; c < 3; c++) begin
      run_sense(12'h020, 12'h010);
      n_total++; if (sense_timeout !== 1'b0) $display("FAIL c%0d_strt_timeout: got %b want 0", c + 2, sense_timeout); else n_pass++;
      repeat (6) @(negedge clk);
      n_total++; if (lft !== exp_l[c]) $display("FAIL c%0d_lft: got %h want %h", c + 2, lft, exp_l[c]); else n_pass++;
      n_total++; if (rht !== exp_r[c]) $display("FAIL c%0d_rht: got %h want %h", c + 2, rht, exp_r[c]); else n_pass++;
    end
  endtask

  // Drop go during the middle-pair gap; a late cnv_cmplt must change nothing.
  task automatic test_go_drop();
    int w; logic [2:0] c; logic [2:0] e; logic to; logic any_to; logic busy;
    any_to = 1'b0;
    for (int i = 0; i < 3; i++) begin
      serve_conv(12'h020, 5000, w, c, e, to);
      any_to |= to;
    end
    n_total++; if (any_to !== 1'b0) $display("FAIL drop_strt_timeout: got %b want 0", any_to); else n_pass++;
    repeat (4) @(negedge clk);
    n_total++; if (IR_mid_en !== 1'b1) $display("FAIL gap_mid_en: got %b want 1", IR_mid_en); else n_pass++;
    go = 1'b0;
    @(negedge clk);
    n_total++; if ({IR_out_en, IR_mid_en, IR_in_en} !== 3'b000)
      $display("FAIL drop_enables: got %b want 000", {IR_out_en, IR_mid_en, IR_in_en}); else n_pass++;
    n_total++; if (strt_cnv !== 1'b0) $display("FAIL drop_strt_cnv: got %b want 0", strt_cnv); else n_pass++;
    n_total++; if (lft !== 11'h000) $display("FAIL drop_lft: got %h want 000", lft); else n_pass++;
    n_total++; if (rht !== 11'h000) $display("FAIL drop_rht: got %h want 000", rht); else n_pass++;
    A2D_res   = 12'hFFF;
    cnv_cmplt = 1'b1;
    @(negedge clk);
    cnv_cmplt = 1'b0;
    busy = 1'b0;
    repeat (50) begin
      @(negedge clk);
      if (strt_cnv !== 1'b0 || {IR_out_en, IR_mid_en, IR_in_en} !== 3'b000) busy = 1'b1;
    end
    n_total++; if (busy !== 1'b0) $display("FAIL late_cmplt_activity: got %b want 0", busy); else n_pass++;
    n_total++; if (LEDs !== 8'h07) $display("FAIL late_cmplt_leds: got %h want 07", LEDs); else n_pass++;
  endtask

  // Restart from IDLE into a saturating error.
  task automatic test_saturation();
    go = 1'b1;
    run_sense(12'hFFF, 12'h000);
    n_total++; if (sense_timeout !== 1'b0) $display("FAIL sat_strt_timeout: got %b want 0", sense_timeout); else n_pass++;
    n_total++; if (waits[0] !== 4097) $display("FAIL restart_strt_delay: got %0d want 4097", waits[0]); else n_pass++;
    repeat (6) @(negedge clk);
    n_total++; if (LEDs !== 8'h7F) $display("FAIL sat_leds: got %h want 7f", LEDs); else n_pass++;
    n_total++; if (lft !== 11'h3FF) $display("FAIL sat_lft: got %h want 3ff", lft); else n_pass++;
    n_total++; if (rht !== 11'h400) $display("FAIL sat_rht: got %h want 400", rht); else n_pass++;
  endtask

  // Asynchronous reset in the middle of a SETTLE phase.
  task automatic test_async_reset();
    n_total++; if (IR_in_en !== 1'b1) $display("FAIL pre_reset_in_en: got %b want 1", IR_in_en); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_total++; if (IR_in_en !== 1'b0) $display("FAIL areset_in_en: got %b want 0", IR_in_en); else n_pass++;
    n_total++; if (lft !== 11'h000) $display("FAIL areset_lft: got %h want 000", lft); else n_pass++;
    n_total++; if (rht !== 11'h000) $display("FAIL areset_rht: got %h want 000", rht); else n_pass++;
    n_total++; if (LEDs !== 8'h00) $display("FAIL areset_leds: got %h want 00", LEDs); else n_pass++;
    @(negedge clk);
    go    = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_first_cycle();
    test_integrator();
    test_go_drop();
    test_saturation();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/motion_cntrl.md
# motion_cntrl

Closed-loop steering controller for the line-follower datapath. It polls three IR sensor pairs (inner, middle, outer) through the shared A2D converter and forms a weighted signed line-position error. A PI controller turns that error into saturated signed 11-bit left and right motor commands. It sits between the A2D interface block and the motor drive block.

## Interface
- P_TERM, 2: unsigned proportional gain (4-bit).
- I_TERM, 1: unsigned integral gain (4-bit).
- FWD_STEP, 11'h010: forward-speed increment per control cycle.
- FWD_MAX, 11'h700: forward-speed ceiling.
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- go  in  1  run enable, level-sensitive.
- strt_cnv  out  1  one-cycle pulse that starts an A2D conversion.
- chnnl  out  3  A2D channel select; held stable from the strt_cnv pulse until cnv_cmplt.
- cnv_cmplt  in  1  one-cycle pulse; A2D_res is valid in that cycle.
- A2D_res  in  12  unsigned conversion result.
- IR_in_en, IR_mid_en, IR_out_en  out  1 each  IR emitter enables for the inner, middle and outer pairs.
- LEDs  out  8  Error[11:4].
- lft, rht  out  11 each  signed motor commands.

## Operation
- Reset values: all outputs 0; Accum, Error, Intgrl, Fwd and the integrator decimation counter are 0.
- IDLE: remains here while go=0. go=1 moves to the SETTLE state of the inner pair.
- Each pair runs this sequence:
  - SETTLE: the pair's enable is high and a 4096-cycle timer runs.
  - CONV_R: strt_cnv pulse with the right channel.
  - WAIT_R: wait for cnv_cmplt, then Accum += res·w.
  - GAP: 32 cycles.
  - CONV_L: strt_cnv pulse with the left channel.
  - WAIT_L: wait for cnv_cmplt, then Accum -= res·w.
- Pair channels (right/left) and weights w:
  - Inner: 1/0, w=1.
  - Middle: 4/2, w=2.
  - Outer: 3/7, w=4.
- Exactly one enable is high, from that pair's SETTLE through its WAIT_L. No enable is high in IDLE or during the post-processing states.
- Accum is 16-bit signed and is cleared when the inner-pair SETTLE state is entered.
- After the outer pair, the post-processing states run in order:
  - INTG: Error = sat12(Accum). Fwd = min(Fwd+FWD_STEP, FWD_MAX). The decimation counter increments; when it wraps to 0 (every 4th cycle), Intgrl = sat12(Intgrl + (Error>>>4)).
  - ITERM: Icomp = Intgrl·I_TERM, 16-bit signed.
  - PTERM: Pcomp = Error·P_TERM, 16-bit signed.
  - MRT_R: rht = sat11(Fwd − Pcomp − Icomp).
  - MRT_L: lft = sat11(Fwd + Pcomp + Icomp). Then return to the inner-pair SETTLE state.
- Saturation ranges: sat12 clamps to [−2048, 2047]; sat11 clamps to [−1024, 1023].
- LEDs update at INTG.
- go=0 in any state: next state is IDLE. Enables and strt_cnv go low, and lft, rht, Fwd, Intgrl and the decimation counter are cleared. A cnv_cmplt that arrives afterwards is ignored.

## Timing
- The first strt_cnv comes 4096 cycles after SETTLE is entered (that is, after go is seen high in IDLE).
- The left strt_cnv comes 33 cycles after the right cnv_cmplt: one cycle to accumulate, then the 32-cycle gap.
- A cnv_cmplt that arrives while the block is not in a WAIT state is ignored. The wait for cnv_cmplt has no timeout.
- Post-processing takes 5 cycles. rht is visible the cycle after MRT_R, and lft the cycle after MRT_L.
- Asynchronous reset mid-operation returns the block to IDLE with all reset values.

## Configuration
- MOTION_CNTRL_I_TERM_EN defined: the integrator operates as described.
- Not defined: Intgrl stays 0 and Icomp=0, giving P-only control. All other timing is unchanged.

## Structure
- Package motion_cntrl_pkg holds:
  - the state enum;
  - the channel constants (1, 0, 4, 2, 3, 7);
  - the weights (1, 2, 4);
  - the 4096-cycle settle and 32-cycle gap counts;
  - the sat12/sat11 limits.
- Sub-module motion_alu is a shared add/subtract/multiply unit with an 11/12-bit saturating output, selected per state.

## Test plan
- Reset: hold rst_n=0 -> all outputs are 0 and the block is in IDLE. With go=0 for 10k cycles -> strt_cnv is never asserted.
- One cycle with results right=0x020 and left=0x010 for every pair, P_TERM=2 -> Error=0x070, LEDs=0x07, lft=0x0F0, rht=0x730 (−0xD0).
- Channel and enable order: strt_cnv at cycle 4096 with chnnl=1 and IR_in_en=1; chnnl=0 33 cycles after the first cnv_cmplt; then chnnl 4, 2, 3, 7 with the matching enables.
- Same stimulus for 4 cycles, macro defined -> at cycle 4 Intgrl=7, lft=0x127, rht=0x759. Macro undefined -> lft=0x120, rht=0x760.
- Saturation: all right results 0xFFF and all left results 0x000 -> Error=0x7FF, LEDs=0x7F, lft=0x3FF, rht=0x400.
- Drop go during the middle-pair GAP -> next cycle the state is IDLE, enables are 0, lft and rht are 0. A late cnv_cmplt is ignored.
